letc_core_stage_fetch2: RTL
===========================

LETC_CORE_STAGE_FETCH2 -- requirements
Module: letc_core_stage_fetch2

Interface
- REQ-001: clk  input  1  core clock; all state updates on posedge clk.
- REQ-002: rst  input  1  asynchronous, active-high reset.
- REQ-003: stage_ready  output  1  high when the stage is not waiting on imem (state IDLE).
- REQ-004: stage_stall  input  1  downstream stall; holds the output register.
- REQ-005: stage_flush  input  1  squash all in-flight work; overrides stage_stall.
- REQ-006: f1_to_f2_valid  input  1  fetch PC offered by F1.
- REQ-007: f1_to_f2_pc  input  32  fetch PC.
- REQ-008: imem_req_valid  output  1  instruction memory request.
- REQ-009: imem_req_addr  output  32  request address (word aligned).
- REQ-010: imem_req_ready  input  1  request accepted this cycle.
- REQ-011: imem_rsp_valid  input  1  response beat; imem has no backpressure.
- REQ-012: imem_rsp_data  input  32  instruction word.
- REQ-013: imem_rsp_fault  input  1  bus access fault on this response.
- REQ-014: f2_to_d_valid  output  1  registered record valid to decode.
- REQ-015: f2_to_d  output  f2_to_d_s  registered record with fields pc[31:0], instr[31:0], excp_misaligned, excp_access_fault.

Function
- REQ-016: FSM states are IDLE, REQ, WAIT, HELD and DISCARD; at most one imem request is outstanding.
- REQ-017: IDLE, accept path: on f1_to_f2_valid & !stage_stall & !stage_flush, capture pc; if pc[1:0]!=0, go to HELD with excp_misaligned=1 and instr=0, issuing no request; otherwise go to REQ.
- REQ-018: REQ: imem_req_valid=1 and imem_req_addr=captured pc; on imem_req_ready, go to WAIT; on stage_flush, go to IDLE without the request counting as accepted.
- REQ-019: WAIT: on imem_rsp_valid, build the record {pc, imem_rsp_data, 0, imem_rsp_fault}; if !stage_stall, load it into the output register (valid next cycle) and go to IDLE; if stage_stall, store it in the 1-entry hold buffer and go to HELD.
- REQ-020: WAIT with stage_flush: if imem_rsp_valid in the same cycle, drop the response and go to IDLE; otherwise go to DISCARD.
- REQ-021: DISCARD: the next imem_rsp_valid is dropped and the FSM goes to IDLE; stage_flush in DISCARD keeps DISCARD.
- REQ-022: HELD: when !stage_stall, move the buffer into the output register and go to IDLE; stage_flush drops the buffer and goes to IDLE.
- REQ-023: Output register: on stage_flush, clear f2_to_d_valid next cycle; else on stage_stall, hold f2_to_d_valid and f2_to_d unchanged; else load the new record (valid=1) or clear valid when there is no new record.
- REQ-024: Latency: PC accepted at cycle N, req_ready at N+1, rsp at N+2 means f2_to_d_valid=1 at N+3; a misaligned PC at N produces its record at N+2.
- REQ-025: stage_ready = (state==IDLE); F1 shall offer a new PC only while stage_ready is high.
- REQ-026: imem_rsp_valid in IDLE, REQ or HELD is a protocol error and shall be ignored.

Reset
- REQ-027: While rst is high, state=IDLE, f2_to_d_valid=0, f2_to_d='0, imem_req_valid=0, imem_req_addr=0 and the hold buffer is cleared, asynchronously.
- REQ-028: Reset deasserted with a request outstanding leaves no DISCARD; the imem shall be reset together with this stage.

Verification
- REQ-029: pc=0x100 offered, req_ready one cycle later, rsp data=0x009433b3 one cycle after that -> f2_to_d_valid=1, pc=0x100, instr=0x009433b3, both excp=0, on the following cycle.
- REQ-030: pc=0x102 -> no imem_req_valid; record with excp_misaligned=1 valid two cycles later.
- REQ-031: stage_stall high when the rsp (0x30401073) arrives -> HELD, stage_ready=0; stall low for 1 cycle -> record valid with instr=0x30401073.
- REQ-032: flush in WAIT with no rsp, then rsp arrives -> DISCARD, rsp dropped, f2_to_d_valid stays 0, then IDLE.
- REQ-033: rsp with imem_rsp_fault=1 at pc=0x200 -> record valid with excp_access_fault=1, pc=0x200.
- REQ-034: rst asserted mid-WAIT -> outputs zero immediately without waiting for clk.

Source files
------------

// File: rtl/letc_core_stage_fetch2.sv
// LETC fetch stage 2: issues the imem request for the F1 PC and
// registers the returned instruction record for decode.
package letc_core_stage_fetch2_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        excp_misaligned;
    logic        excp_access_fault;
  } f2_to_d_s;
endpackage

module letc_core_stage_fetch2
  import letc_core_stage_fetch2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        stage_ready,
  input  logic        stage_stall,
  input  logic        stage_flush,
  input  logic        f1_to_f2_valid,
  input  logic [31:0] f1_to_f2_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_fault,
  output logic        f2_to_d_valid,
  output f2_to_d_s    f2_to_d
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, HELD, DISCARD
  } state_e;

  state_e      state, state_next;
  logic [31:0] pc_q, pc_next;
  f2_to_d_s    hold_q, hold_next;
  f2_to_d_s    rsp_rec, load_rec;
  logic        load;

  assign stage_ready    = (state == IDLE);
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = {pc_q[31:2], 2'b00};

  always_comb begin
    rsp_rec.pc                = pc_q;
    rsp_rec.instr             = imem_rsp_data;
    rsp_rec.excp_misaligned   = 1'b0;
    rsp_rec.excp_access_fault = imem_rsp_fault;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    hold_next  = hold_q;
    load       = 1'b0;
    load_rec   = hold_q;
    unique case (state)
      IDLE: begin
        if (f1_to_f2_valid && !stage_stall && !stage_flush) begin
          pc_next = f1_to_f2_pc;
          // Misaligned PCs never reach imem; the record goes straight out.
          if (|f1_to_f2_pc[1:0]) begin
            hold_next  = {f1_to_f2_pc, 32'h0, 1'b1, 1'b0};
            state_next = HELD;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (stage_flush)         state_next = IDLE;
        else if (imem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (stage_flush) begin
            state_next = IDLE;
          end else if (stage_stall) begin
            hold_next  = rsp_rec;
            state_next = HELD;
          end else begin
            load       = 1'b1;
            load_rec   = rsp_rec;
            state_next = IDLE;
          end
        end else if (stage_flush) begin
          state_next = DISCARD;
        end
      end
      HELD: begin
        if (stage_flush) begin
          hold_next  = '0;
          state_next = IDLE;
        end else if (!stage_stall) begin
          load       = 1'b1;
          load_rec   = hold_q;
          state_next = IDLE;
        end
      end
      DISCARD: begin
        if (imem_rsp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc_q   <= '0;
      hold_q <= '0;
    end else begin
      state  <= state_next;
      pc_q   <= pc_next;
      hold_q <= hold_next;
    end
  end

  // Flush beats stall; stall freezes the whole output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f2_to_d_valid <= 1'b0;
      f2_to_d       <= '0;
    end else if (stage_flush) begin
      f2_to_d_valid <= 1'b0;
    end else if (!stage_stall) begin
      f2_to_d_valid <= load;
      if (load) f2_to_d <= load_rec;
    end
  end

endmodule
